// File: rtl/read_pulse_pacer_pkg.sv
// ---------------------------------------------------------------------------
// read_pulse_pacer_pkg
// Shared encodings and default constants for the read pulse pacer and the
// fast2slow pulse path it feeds.
// Rev 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

package read_pulse_pacer_pkg;

  // Pacer FSM encodings
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FIRE = 2'd1,
    GAP  = 2'd2
  } pacer_state_t;

  // Default spacing: 8 cycles at 50 MHz = 160 ns, >2 cycles of a 3x-slower clock
  localparam int unsigned C_GAP_CYCLES = 8;
  // Default pending-counter width (saturates at 15)
  localparam int unsigned C_CNT_W      = 4;
  // Gap timer width, enough for the full 2..255 spacing range
  localparam int unsigned C_TIMER_W    = 8;

endpackage

`default_nettype wire

// File: rtl/read_pulse_pacer_gap_timer.sv
// ---------------------------------------------------------------------------
// read_pulse_pacer_gap_timer
// Loadable down-counter with a zero flag. Holds at zero; load has priority
// over decrement.
// Rev 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module read_pulse_pacer_gap_timer
  import read_pulse_pacer_pkg::*;
#(
  parameter int unsigned W = C_TIMER_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_dec,
  output logic         o_zero
);

  logic [W-1:0] r_value;

  // Count register: load wins, otherwise decrement until zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_value <= '0;
    end else if (i_load) begin
      r_value <= i_load_val;
    end else if (i_dec && (r_value != '0)) begin
      r_value <= r_value - W'(1);
    end
  end

  assign o_zero = (r_value == '0);

endmodule

`default_nettype wire

// File: rtl/read_pulse_pacer.sv
// ---------------------------------------------------------------------------
// read_pulse_pacer
// Queues single-cycle read strobes in a saturating counter and re-emits them
// as single-cycle read pulses spaced GAP_CYCLES apart, so a downstream
// fast-to-slow pulse synchronizer never merges or drops a pulse.
// Rev 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module read_pulse_pacer
  import read_pulse_pacer_pkg::*;
#(
  parameter int unsigned GAP_CYCLES = C_GAP_CYCLES,
  parameter int unsigned CNT_W      = C_CNT_W
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  input  logic             req,
  input  logic             en,
  input  logic             ovf_clr,
  output logic             read,
  output logic [CNT_W-1:0] pending,
  output logic             busy,
  output logic             ovf
);

  // FIRE occupies one cycle of the spacing, GAP the remaining GAP_CYCLES-1,
  // and the timer's zero cycle is itself a GAP cycle, hence the -2.
  localparam logic [C_TIMER_W-1:0] c_gap_load = C_TIMER_W'(GAP_CYCLES - 2);

  pacer_state_t     r_state;
  pacer_state_t     w_state_next;
  logic [CNT_W-1:0] r_pending;
  logic [CNT_W-1:0] w_pending_next;
  logic             r_read;
  logic             r_busy;
  logic             r_ovf;
  logic             w_gap_zero;
  logic             w_can_fire;
  logic             w_take;
  logic             w_sat;
  logic             w_drop;
  logic             w_inc;

  assign w_can_fire = en && ((r_pending != '0) || req);
  assign w_take     = (w_state_next == FIRE);
  assign w_sat      = (r_pending == {CNT_W{1'b1}});
  // A request is only lost when full and nothing leaves on the same edge
  assign w_drop     = req && w_sat && !w_take;
  assign w_inc      = req && !w_drop;

  // Next-state decode; en gates only the entry into FIRE
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE: if (w_can_fire) w_state_next = FIRE;
      FIRE: w_state_next = GAP;
      GAP: begin
        if (w_gap_zero) begin
          w_state_next = w_can_fire ? FIRE : IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  assign w_pending_next = r_pending + CNT_W'(w_inc) - CNT_W'(w_take);

  // State register
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Pending counter and registered read/busy outputs
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_pending <= '0;
      r_read    <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      r_pending <= w_pending_next;
      r_read    <= (w_state_next == FIRE);
      r_busy    <= (w_state_next != IDLE) || (w_pending_next != '0);
    end
  end

  // Sticky overflow flag; a drop on the clearing edge keeps it set
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_ovf <= 1'b0;
    end else if (w_drop) begin
      r_ovf <= 1'b1;
    end else if (ovf_clr) begin
      r_ovf <= 1'b0;
    end
  end

  read_pulse_pacer_gap_timer #(
    .W (C_TIMER_W)
  ) u_gap_timer (
    .clk        (sys_clk),
    .rst_n      (sys_rst_n),
    .i_load     (w_take),
    .i_load_val (c_gap_load),
    .i_dec      (r_state == GAP),
    .o_zero     (w_gap_zero)
  );

  assign read    = r_read;
  assign pending = r_pending;
  assign busy    = r_busy;
  assign ovf     = r_ovf;

endmodule

`default_nettype wire

// File: tb/tb_read_pulse_pacer.sv
// ---------------------------------------------------------------------------
// tb_read_pulse_pacer
// Directed self-checking bench for read_pulse_pacer (GAP_CYCLES=8, CNT_W=4).
// Rev 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module tb_read_pulse_pacer;

  logic       sys_clk   = 1'b0;
  logic       sys_rst_n = 1'b0;
  logic       req       = 1'b0;
  logic       en        = 1'b0;
  logic       ovf_clr   = 1'b0;
  logic       read;
  logic [3:0] pending;
  logic       busy;
  logic       ovf;

  int n_tests = 0;
  int n_fail  = 0;

  read_pulse_pacer #(
    .GAP_CYCLES (8),
    .CNT_W      (4)
  ) dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .req       (req),
    .en        (en),
    .ovf_clr   (ovf_clr),
    .read      (read),
    .pending   (pending),
    .busy      (busy),
    .ovf       (ovf)
  );

  // 50 MHz clock
  always #10 sys_clk = ~sys_clk;

  // Single comparison point
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance one edge; inputs change and outputs are sampled 1 ns after it
  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic do_reset();
    req       = 1'b0;
    en        = 1'b0;
    ovf_clr   = 1'b0;
    sys_rst_n = 1'b0;
    repeat (2) tick();
    sys_rst_n = 1'b1;
    tick();
  endtask

  // Expect n-1 quiet cycles then a read pulse on the n-th
  task automatic wait_read(input string tag, input int n);
    int r;
    r = 0;
    repeat (n - 1) begin
      tick();
      r += int'(read);
    end
    chk({tag, "_quiet"}, r, 0);
    tick();
    chk(tag, read, 1);
  endtask

  initial begin
    int r;
    int b;

    // Reset state
    do_reset();
    chk("rst_read", read, 0);
    chk("rst_pending", pending, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ovf", ovf, 0);

    // 1: single request, 1-cycle latency, busy for 8 cycles
    en  = 1'b1;
    req = 1'b1;
    tick();
    req = 1'b0;
    chk("t1_read", read, 1);
    chk("t1_pending", pending, 0);
    chk("t1_busy", busy, 1);
    r = 0; b = 0;
    repeat (7) begin
      tick();
      r += int'(read);
      b += int'(busy);
    end
    chk("t1_single_pulse", r, 0);
    chk("t1_busy_cycles", b, 7);
    tick();
    chk("t1_busy_off", busy, 0);

    // 2: three back-to-back requests
    do_reset();
    en  = 1'b1;
    req = 1'b1;
    tick();
    chk("t2_read0", read, 1);
    chk("t2_pend_e10", pending, 0);
    tick();
    chk("t2_pend_e11", pending, 1);
    tick();
    req = 1'b0;
    chk("t2_pend_e12", pending, 2);
    wait_read("t2_read1", 6);
    chk("t2_pend_r1", pending, 1);
    wait_read("t2_read2", 8);
    chk("t2_pend_r2", pending, 0);
    repeat (8) tick();
    chk("t2_busy_off", busy, 0);

    // 3: saturation, overflow, clear priority, drain at fixed spacing
    do_reset();
    en  = 1'b0;
    req = 1'b1;
    repeat (15) tick();
    chk("t3_pend_15", pending, 15);
    chk("t3_ovf_pre", ovf, 0);
    tick();
    chk("t3_pend_sat", pending, 15);
    chk("t3_ovf_set", ovf, 1);
    ovf_clr = 1'b1;
    tick();
    chk("t3_set_wins", ovf, 1);
    req = 1'b0;
    tick();
    ovf_clr = 1'b0;
    chk("t3_ovf_clr", ovf, 0);
    chk("t3_no_fire_en0", read, 0);
    en = 1'b1;
    tick();
    chk("t3_first_read", read, 1);
    chk("t3_pend_14", pending, 14);
    for (int k = 0; k < 14; k++) begin
      wait_read($sformatf("t3_read%0d", k + 1), 8);
    end
    chk("t3_pend_empty", pending, 0);
    r = 0;
    repeat (8) begin
      tick();
      r += int'(read);
    end
    chk("t3_no_extra", r, 0);
    chk("t3_busy_off", busy, 0);

    // 4: request coincides with FIRE entry while one is pending
    do_reset();
    en  = 1'b0;
    req = 1'b1;
    tick();
    req = 1'b0;
    chk("t4_pend_1", pending, 1);
    en  = 1'b1;
    req = 1'b1;
    tick();
    req = 1'b0;
    chk("t4_read", read, 1);
    chk("t4_pend_hold", pending, 1);
    chk("t4_ovf", ovf, 0);
    wait_read("t4_read2", 8);
    chk("t4_pend_0", pending, 0);

    // 5: asynchronous reset mid-GAP
    do_reset();
    en  = 1'b1;
    req = 1'b1;
    repeat (4) tick();
    req = 1'b0;
    chk("t5_pend_3", pending, 3);
    repeat (2) tick();
    #5;
    sys_rst_n = 1'b0;
    #1;
    chk("t5_async_read", read, 0);
    chk("t5_async_pend", pending, 0);
    chk("t5_async_busy", busy, 0);
    chk("t5_async_ovf", ovf, 0);
    #4;
    sys_rst_n = 1'b1;
    r = 0; b = 0;
    repeat (20) begin
      tick();
      r += int'(read);
      b += int'(busy);
    end
    chk("t5_no_replay", r, 0);
    chk("t5_idle_busy", b, 0);

    // 6: two requests 6 cycles apart become pulses 8 cycles apart
    do_reset();
    en  = 1'b1;
    req = 1'b1;
    tick();
    req = 1'b0;
    chk("t6_read1", read, 1);
    r = 0;
    repeat (5) begin
      tick();
      r += int'(read);
    end
    req = 1'b1;
    tick();
    req = 1'b0;
    r += int'(read);
    chk("t6_pend_queued", pending, 1);
    tick();
    r += int'(read);
    chk("t6_quiet", r, 0);
    tick();
    chk("t6_read2", read, 1);
    chk("t6_pend_0", pending, 0);
    r = 0;
    repeat (20) begin
      tick();
      r += int'(read);
    end
    chk("t6_two_only", r, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/read_pulse_pacer.md
Name: read_pulse_pacer

Overview:
- Fast-domain stage directly upstream of the fast2slow pulse synchronizer.
- Accepts single-cycle read request strobes on sys_clk, which may arrive back-to-back.
- Queues them in a saturating pending counter.
- Re-emits them as single-cycle read pulses spaced at least GAP_CYCLES apart, so the slow-domain synchronizer never merges or drops a pulse.

Parameters:
- GAP_CYCLES, 8: minimum sys_clk cycles between consecutive read rising edges; legal range 2..255. 8 gives 160 ns at 50 MHz, which covers 2+ cycles of the 3x-slower clock.
- CNT_W, 4: width of the pending-request counter; saturation value is 2^CNT_W-1.

Ports:
- sys_clk  in  1  fast-domain clock; all logic is on its rising edge.
- sys_rst_n  in  1  reset; asynchronous assert, active-low.
- req  in  1  read request strobe; each high cycle is one request.
- en  in  1  fire enable; when low, requests still accumulate but no new pulse starts.
- ovf_clr  in  1  clears the sticky overflow flag.
- read  out  1  paced single-cycle read pulse, driving the synchronizer's read input.
- pending  out  CNT_W  number of queued requests not yet emitted.
- busy  out  1  high when the state is not IDLE or pending != 0.
- ovf  out  1  sticky flag: a request was dropped because the counter was saturated.

Behaviour:
- Reset is asynchronous and active-low:
  - read=0, pending=0, ovf=0, busy=0.
  - FSM goes to IDLE and the gap counter goes to 0.
  - A pulse or gap in flight is abandoned; nothing is replayed after release.
- All outputs are registered; read is decoded from state == FIRE.
- FSM states: IDLE, FIRE, GAP.
  - IDLE -> FIRE at an edge where en && (pending != 0 || req).
  - FIRE lasts exactly 1 cycle with read=1. At its entry edge, gap_cnt is loaded with GAP_CYCLES-2. FIRE always goes to GAP.
  - GAP lasts GAP_CYCLES-1 cycles, decrementing gap_cnt.
  - At the last GAP cycle (gap_cnt == 0): go to FIRE if en && (pending != 0 || req), else go to IDLE.
- Pulse spacing and latency:
  - Consecutive read pulses are exactly GAP_CYCLES apart while work is queued and en=1.
  - Latency from req sampled at edge k, in IDLE with en=1, to read high is 1 cycle: read is high in the cycle after edge k.
- Counter update: pending_next = pending + inc - take.
  - take = 1 on the edge that enters FIRE.
  - inc = req, unless pending is at max and take = 0; in that case the request is dropped and ovf is set.
  - A req with pending=0 at the same edge as the FIRE entry it triggers gives a net change of 0.
  - A simultaneous req and take gives pending unchanged, so it never overflows.
- ovf:
  - Set on a dropped request.
  - Cleared by ovf_clr.
  - If set and clear occur on the same edge, set wins.
- en:
  - Gates only the transition into FIRE.
  - Dropping en during FIRE or GAP does not truncate them; the FSM finishes GAP and then goes to IDLE.
- req is assumed synchronous to sys_clk; no internal input synchronizer.

Decomposition:
- Shared include/package (fast2slow_pkg):
  - state encodings IDLE=2'd0, FIRE=2'd1, GAP=2'd2.
  - default GAP_CYCLES and CNT_W constants, shared with fast2slow and its bench.
- One sub-module: pacer_gap_timer.
  - Loadable down-counter with load, value and zero flag, 8 bits wide.
  - Everything else stays flat in read_pulse_pacer.

Test Plan:
1. Single req at cycle 10, en=1 -> read high in cycle 11 only; pending stays 0; busy high in cycles 11..18, low from cycle 19.
2. req high cycles 10..12 -> read in cycles 11, 19, 27; pending reads 1 after edge 11 and 2 after edge 12; it is 0 after edge 26.
3. en=0, 16 consecutive reqs -> pending=15, ovf=1 after the 16th. Pulse ovf_clr -> ovf=0. Set en=1 -> 15 read pulses exactly 8 cycles apart, then busy=0.
4. pending=1 and req coincides with the FIRE entry edge -> pending stays 1 and ovf stays 0. Next read comes 8 cycles later, then pending=0.
5. sys_rst_n dropped mid-GAP with pending=3 -> read, pending, busy and ovf go to 0 immediately, without waiting for a clock edge. After release with no req, read stays 0 for at least 20 cycles.
6. Two reqs 6 cycles apart (120 ns at a 20 ns clock), with the pacer feeding fast2slow with clk_slow=60 ns -> read pulses 8 cycles apart. read_sync_pulse shows exactly 2 distinct slow-domain pulses.
